// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle 32x32->64 multiply sequencer for MULT/MULTU.
// One 32-bit ripple adder is reused over 32 iterations. Signed operands use
// radix-2 Booth recoding and unsigned operands use plain shift-add. The
// result lands in hi/lo on entry to the DONE state.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request; accepted only when busy == 0
//   is_signed  in   1   1 = MULT (Booth), 0 = MULTU (shift-add); sampled on accept
//   op_a       in   32  multiplicand; sampled on accept
//   op_b       in   32  multiplier; sampled on accept
//   flush      in   1   synchronous abort; drops the operation in flight
//   busy       out  1   state != IDLE
//   done       out  1   one-cycle pulse; hi/lo hold the new product
//   hi         out  32  product[63:32]
//   lo         out  32  product[31:0]
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;     // partial-product accumulator (upper half)
  logic [WIDTH-1:0]   q_q, q_d;     // multiplier, shifted out as product bits shift in
  logic [WIDTH-1:0]   m_q, m_d;     // multiplicand
  logic               qm1_q, qm1_d; // Booth look-behind bit
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Adder operands and results
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic               cout;
  logic               ovf;
  logic               ins;
  logic [2*WIDTH-1:0] shifted;

  // Operand selection: Booth pair {Q[0], q_m1} in signed mode, Q[0] otherwise.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    if (mode_q) begin
      unique case ({q_q[0], qm1_q})
        2'b01: begin
          add_b   = m_q;
          add_cin = 1'b0;
        end
        2'b10: begin
          add_b   = ~m_q;
          add_cin = 1'b1;
        end
        default: begin
          add_b   = '0;
          add_cin = 1'b0;
        end
      endcase
    end else begin
      add_b = q_q[0] ? m_q : '0;
    end
  end

  // Ripple-carry adder: a = A, b = add_b, cin = add_cin.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = add_cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a_q[i] ^ add_b[i] ^ carry[i];
      carry[i+1] = (a_q[i] & add_b[i]) | (a_q[i] & carry[i]) | (add_b[i] & carry[i]);
    end
    cout = carry[WIDTH];
    ovf  = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Bit shifted into A[31]: true sign of A+/-M in signed mode (survives
  // overflow, e.g. subtracting 0x80000000), carry-out in unsigned mode.
  assign ins     = mode_q ? (sum[WIDTH-1] ^ ovf) : cout;
  assign shifted = {ins, sum, q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        // Flush in IDLE wins over start so an aborted slot cannot launch.
        if (start && !flush) begin
          m_d     = op_a;
          q_d     = op_b;
          a_d     = '0;
          qm1_d   = 1'b0;
          mode_d  = is_signed;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          a_d   = shifted[2*WIDTH-1:WIDTH];
          q_d   = shifted[WIDTH-1:0];
          qm1_d = q_q[0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
            hi_d    = shifted[2*WIDTH-1:WIDTH];
            lo_d    = shifted[WIDTH-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
